// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle between a program loader
// (master) and the instruction encoder (slave).
interface instr_encoder_loader_if #(
  parameter int AW = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [2:0]        req_ra;
  logic [2:0]        req_rb;
  logic [2:0]        req_mode;
  logic [4:0]        req_imm;
  logic              imem_we;
  logic [AW-1:0]     imem_addr;
  logic [8:0]        imem_wdata;
  logic [AW:0]       word_count;
  logic              full;
  logic              err;

  modport master (
    output req_valid, req_op, req_ra, req_rb, req_mode, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata, word_count, full, err
  );

  modport slave (
    input  req_valid, req_op, req_ra, req_rb, req_mode, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata, word_count, full, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Streaming instruction encoder: packs symbolic requests into 9-bit words and
// writes them sequentially from address 0. ADDIW expands into two AddI words.
module instr_encoder_loader #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  instr_encoder_loader_if.slave   bus
);

  typedef enum logic {IDLE, EMIT2} state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [8:0]          wdata_q;
  logic [AW:0]         count_q;
  logic                err_q;
  logic [8:0]          word2_q;

  logic                full;
  logic                ready;
  logic                fire;
  logic                legal;
  logic                is_addiw;
  logic                room2;
  logic                emit;
  logic                set_err;
  logic [8:0]          emit_word;
  logic [8:0]          word1;
  logic [8:0]          word2;
  logic signed [4:0]   imm;
  logic signed [4:0]   imm_lo;
  logic signed [4:0]   imm_hi;

  // Field legality against the ISA for every opcode.
  function automatic logic is_legal(input logic [3:0] op, input logic [2:0] ra,
                                    input logic [2:0] mode, input logic [4:0] im);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd7, 4'd8: is_legal = 1'b1;
      4'd3, 4'd4:                   is_legal = ~ra[2];
      4'd5:                         is_legal = ra[2] & (im[4] == im[3]);
      4'd6:                         is_legal = (mode == 3'b000) | (mode == 3'b010) |
                                               (mode == 3'b011) | (mode == 3'b100) |
                                               (mode == 3'b110);
      4'd9:                         is_legal = ra[2] & (im != 5'b01111);
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  // One AddI word; the immediate must already fit in 4 signed bits.
  function automatic logic [8:0] addi_word(input logic [2:0] ra, input logic signed [4:0] im);
    addi_word = {3'b100, ra[1:0], im[3:0]};
  endfunction

  // Single-word encoding; for ADDIW this is the first of the pair.
  function automatic logic [8:0] encode(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] mode,
                                        input logic signed [4:0] im,
                                        input logic signed [4:0] im_lo);
    case (op)
      4'd0:    encode = {3'b000, ra, rb};
      4'd1:    encode = {3'b001, ra, rb};
      4'd2:    encode = {3'b010, ra, rb};
      4'd3:    encode = {3'b011, ra[1:0], 1'b0, rb};
      4'd4:    encode = {3'b011, ra[1:0], 1'b1, rb};
      4'd5:    encode = addi_word(ra, im);
      4'd6:    encode = {3'b101, ra, mode};
      4'd7:    encode = {3'b110, ra, mode};
      4'd8:    encode = {3'b111, ra, mode};
      4'd9:    encode = addi_word(ra, im_lo);
      default: encode = 9'd0;
    endcase
  endfunction

  // ADDIW split: the halves differ by at most one, so both fit 4-bit signed.
  assign imm    = bus.req_imm;
  assign imm_lo = imm >>> 1;
  assign imm_hi = imm - imm_lo;

  assign word1    = encode(bus.req_op, bus.req_ra, bus.req_rb, bus.req_mode, imm, imm_lo);
  assign word2    = addi_word(bus.req_ra, imm_hi);
  assign legal    = is_legal(bus.req_op, bus.req_ra, bus.req_mode, bus.req_imm);
  assign is_addiw = (bus.req_op == 4'd9);
  assign room2    = ({1'b0, count_q} + (AW+2)'(2)) <= (AW+2)'(DEPTH);

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign ready = (state_q == IDLE) & ~full & ~clear;
  assign fire  = bus.req_valid & ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: only a legal ADDIW with room for both words enters EMIT2.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fire && is_addiw && legal && room2) state_d = EMIT2;
        EMIT2:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: what (if anything) gets written at the next edge.
  always_comb begin
    emit      = 1'b0;
    set_err   = 1'b0;
    emit_word = word1;
    if (!clear) begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            if (!legal || (is_addiw && !room2)) set_err = 1'b1;
            else                                emit    = 1'b1;
          end
        end
        EMIT2: begin
          emit      = 1'b1;
          emit_word = word2_q;
        end
        default: ;
      endcase
    end
  end

  // Write port, word counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= emit;
      if (emit) begin
        addr_q  <= count_q[AW-1:0];
        wdata_q <= emit_word;
        count_q <= count_q + (AW+1)'(1);
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  // Second ADDIW word held for the EMIT2 cycle; only read when state says so.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && fire) word2_q <= word2;
  end

  assign bus.req_ready  = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.word_count = count_q;
  assign bus.full       = full;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a full-size instance (a) and a
// four-word instance (b) share the same stimulus.
module tb_instr_encoder_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] op = '0;
  logic [2:0] ra = '0;
  logic [2:0] rb = '0;
  logic [2:0] mode = '0;
  logic [4:0] imm = '0;
  logic       rdy_a, rdy_b;
  int         checks = 0;
  int         passes = 0;

  instr_encoder_loader_if #(.AW(8)) ifa ();
  instr_encoder_loader_if #(.AW(2)) ifb ();

  assign ifa.req_valid = valid;
  assign ifa.req_op    = op;
  assign ifa.req_ra    = ra;
  assign ifa.req_rb    = rb;
  assign ifa.req_mode  = mode;
  assign ifa.req_imm   = imm;
  assign ifb.req_valid = valid;
  assign ifb.req_op    = op;
  assign ifb.req_ra    = ra;
  assign ifb.req_rb    = rb;
  assign ifb.req_mode  = mode;
  assign ifb.req_imm   = imm;

  instr_encoder_loader #(.AW(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(ifa.slave)
  );
  instr_encoder_loader #(.AW(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One request held for exactly one rising edge; ready sampled before it.
  task automatic send(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] m, input logic [4:0] i);
    @(negedge clk);
    valid = 1'b1; op = o; ra = a; rb = b; mode = m; imm = i;
    #1;
    rdy_a = ifa.req_ready;
    rdy_b = ifb.req_ready;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic do_clear(input logic with_req);
    @(negedge clk);
    clear = 1'b1;
    valid = with_req; op = 4'd0; ra = 3'd1; rb = 3'd2; mode = 3'd0; imm = 5'd0;
    #1;
    rdy_a = ifa.req_ready;
    @(posedge clk);
    #1;
    clear = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(ifa.imem_we), 32'd0);
    chk("rst_addr",  32'(ifa.imem_addr), 32'd0);
    chk("rst_wdata", 32'(ifa.imem_wdata), 32'd0);
    chk("rst_count", 32'(ifa.word_count), 32'd0);
    chk("rst_err",   32'(ifa.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD
    send(4'd0, 3'd1, 3'd2, 3'd0, 5'd0);
    chk("add_we",    32'(ifa.imem_we), 32'd1);
    chk("add_addr",  32'(ifa.imem_addr), 32'd0);
    chk("add_wdata", 32'(ifa.imem_wdata), 32'h00A);
    chk("add_count", 32'(ifa.word_count), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_we",   32'(ifa.imem_we), 32'd0);
    chk("idle_hold", 32'(ifa.imem_wdata), 32'h00A);

    // Clear wins over a concurrent request
    do_clear(1'b1);
    chk("clr_ready", 32'(rdy_a), 32'd0);
    chk("clr_we",    32'(ifa.imem_we), 32'd0);
    chk("clr_count", 32'(ifa.word_count), 32'd0);

    // ADDI then LOD back to back
    send(4'd5, 3'd5, 3'd0, 3'd0, 5'h1D);
    chk("addi_ready", 32'(rdy_a), 32'd1);
    chk("addi_addr",  32'(ifa.imem_addr), 32'd0);
    chk("addi_wdata", 32'(ifa.imem_wdata), 32'h11D);
    send(4'd3, 3'd2, 3'd5, 3'd0, 5'd0);
    chk("lod_ready",  32'(rdy_a), 32'd1);
    chk("lod_we",     32'(ifa.imem_we), 32'd1);
    chk("lod_addr",   32'(ifa.imem_addr), 32'd1);
    chk("lod_wdata",  32'(ifa.imem_wdata), 32'h0E5);
    chk("lod_count",  32'(ifa.word_count), 32'd2);

    // ADDIW expansion
    do_clear(1'b0);
    send(4'd9, 3'd6, 3'd0, 3'd0, 5'd14);
    chk("w14a_we",    32'(ifa.imem_we), 32'd1);
    chk("w14a_addr",  32'(ifa.imem_addr), 32'd0);
    chk("w14a_wdata", 32'(ifa.imem_wdata), 32'h127);
    chk("w14_busy",   32'(ifa.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("w14b_we",    32'(ifa.imem_we), 32'd1);
    chk("w14b_addr",  32'(ifa.imem_addr), 32'd1);
    chk("w14b_wdata", 32'(ifa.imem_wdata), 32'h127);
    chk("w14_ready",  32'(ifa.req_ready), 32'd1);
    send(4'd9, 3'd6, 3'd0, 3'd0, 5'h10);
    chk("wm16a_addr",  32'(ifa.imem_addr), 32'd2);
    chk("wm16a_wdata", 32'(ifa.imem_wdata), 32'h128);
    @(posedge clk);
    #1;
    chk("wm16b_addr",  32'(ifa.imem_addr), 32'd3);
    chk("wm16b_wdata", 32'(ifa.imem_wdata), 32'h128);
    chk("wm16_count",  32'(ifa.word_count), 32'd4);

    // Illegal requests
    do_clear(1'b0);
    send(4'd6, 3'd0, 3'd0, 3'd1, 5'd0);
    chk("ill_shift_we",  32'(ifa.imem_we), 32'd0);
    chk("ill_shift_err", 32'(ifa.err), 32'd1);
    send(4'd3, 3'd5, 3'd1, 3'd0, 5'd0);
    chk("ill_lod_we",    32'(ifa.imem_we), 32'd0);
    send(4'd5, 3'd5, 3'd0, 3'd0, 5'd9);
    chk("ill_addi_we",   32'(ifa.imem_we), 32'd0);
    send(4'd9, 3'd6, 3'd0, 3'd0, 5'd15);
    chk("ill_addiw_we",  32'(ifa.imem_we), 32'd0);
    send(4'd12, 3'd0, 3'd0, 3'd0, 5'd0);
    chk("ill_op_we",     32'(ifa.imem_we), 32'd0);
    chk("ill_count",     32'(ifa.word_count), 32'd0);
    chk("ill_err",       32'(ifa.err), 32'd1);
    do_clear(1'b0);
    chk("clr_err",       32'(ifa.err), 32'd0);
    chk("clr_count2",    32'(ifa.word_count), 32'd0);

    // Four-word instance: overflow drop and full
    for (int k = 0; k < 3; k++) begin
      send(4'd4, 3'd1, 3'd3, 3'd0, 5'd0);
      chk("sto_addr",  32'(ifb.imem_addr), 32'(k));
      chk("sto_wdata", 32'(ifb.imem_wdata), 32'h0DB);
    end
    send(4'd9, 3'd6, 3'd0, 3'd0, 5'd2);
    chk("ovf_we",    32'(ifb.imem_we), 32'd0);
    chk("ovf_err",   32'(ifb.err), 32'd1);
    chk("ovf_count", 32'(ifb.word_count), 32'd3);
    send(4'd7, 3'd3, 3'd0, 3'd1, 5'd0);
    chk("br_we",     32'(ifb.imem_we), 32'd1);
    chk("br_addr",   32'(ifb.imem_addr), 32'd3);
    chk("br_wdata",  32'(ifb.imem_wdata), 32'h199);
    chk("br_count",  32'(ifb.word_count), 32'd4);
    chk("br_full",   32'(ifb.full), 32'd1);
    chk("br_ready",  32'(ifb.req_ready), 32'd0);
    send(4'd0, 3'd1, 3'd2, 3'd0, 5'd0);
    chk("full_rdy",   32'(rdy_b), 32'd0);
    chk("full_we",    32'(ifb.imem_we), 32'd0);
    chk("full_count", 32'(ifb.word_count), 32'd4);
    chk("full_addr",  32'(ifb.imem_addr), 32'd3);

    // Reset during EMIT2
    do_clear(1'b0);
    send(4'd9, 3'd6, 3'd0, 3'd0, 5'd14);
    chk("mid_we", 32'(ifa.imem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    32'(ifa.imem_we), 32'd0);
    chk("mid_rst_wdata", 32'(ifa.imem_wdata), 32'd0);
    chk("mid_rst_count", 32'(ifa.word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_no_word2", 32'(ifa.imem_we), 32'd0);
    send(4'd0, 3'd1, 3'd2, 3'd0, 5'd0);
    chk("post_addr",  32'(ifa.imem_addr), 32'd0);
    chk("post_wdata", 32'(ifa.imem_wdata), 32'h00A);
    chk("post_count", 32'(ifa.word_count), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streaming instruction encoder, the inverse of the control decoder. It takes symbolic instruction requests through a valid/ready handshake and packs them into 9-bit machine words. Words are written sequentially into instruction memory from address 0. It checks field legality against the ISA, and expands the ADDIW pseudo-op into two AddI words. It sits between the test or host program loader and the instruction ROM write port.

Parameters:
AW, 8, instruction memory address width
DEPTH, 256, number of writable words (must be ≤ 2**AW)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous restart: addr/count to 0, err cleared, state IDLE, in-flight ADDIW dropped
req_valid  in  1  request present
req_ready  out  1  encoder can accept
req_op  in  4  0 ADD,1 XOR,2 AND,3 LOD,4 STO,5 ADDI,6 SHIFT,7 BRANCH,8 PARITY,9 ADDIW, 10-15 illegal
req_ra  in  3  first register
req_rb  in  3  second register (ADD/XOR/AND, LOD/STO address reg)
req_mode  in  3  SHIFT/BRANCH/PARITY mode
req_imm  in  5  signed immediate (ADDI, ADDIW)
imem_we  out  1  write strobe
imem_addr  out  AW  write address
imem_wdata  out  9  encoded word
word_count  out  AW+1  words written since reset/clear
full  out  1  word_count == DEPTH
err  out  1  sticky: illegal request or overflow

Behaviour:
Reset values: imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, err=0, state IDLE.

Handshake and ready:
- A transfer happens on a rising edge with req_valid & req_ready.
- req_ready = (state==IDLE) & ~full & ~clear.

Encoding (bits [8:6] opcode):
- ADD/XOR/AND: {000/001/010, ra, rb}.
- LOD: {011, ra[1:0], 0, rb}. STO: {011, ra[1:0], 1, rb}. Legal only if ra[2]==0.
- ADDI: {100, ra[1:0], imm[3:0]}. Legal only if ra[2]==1 and imm in -8..7 (imm[4]==imm[3]).
- SHIFT: {101, ra, mode}. Legal only if mode ∈ {000,010,011,100,110}.
- BRANCH: {110, ra, mode}. mode bit0 = abs, bit1 = flag, bit2 = invert. All modes legal.
- PARITY: {111, ra, mode}. All legal.
- ADDIW: legal only if ra[2]==1 and imm in -16..14.
  - i1 = imm>>>1 (arithmetic); i2 = imm - i1. Both fit 4-bit signed.
  - Emits {100,ra[1:0],i1[3:0]} then {100,ra[1:0],i2[3:0]}.

Timing:
- Accepted at edge N: imem_we=1 with word/addr during cycle N..N+1. The memory captures it at edge N+1. imem_addr = word_count before the increment; word_count increments at the same edge.
- Single-word ops sustain one per cycle.
- ADDIW: IDLE→EMIT2 at accept. The first word is presented like a single-word op. In EMIT2, req_ready=0 and the second word is presented next cycle, then →IDLE.
- Illegal request: the handshake still completes, nothing is written (imem_we=0 next cycle), err←1.
- ADDIW accepted with exactly one free slot: whole op dropped, nothing written, err←1.
- imem_we=0 whenever nothing is emitted; imem_wdata holds its last value.

Boundaries and corner cases:
- full: req_ready=0 until clear. word_count saturates at DEPTH; the address never wraps.
- clear has priority over a concurrent handshake. The request is not accepted, and imem_we=0 next cycle.
- Reset mid-ADDIW: the second word is never emitted.

Test Plan:
- After reset, ADD ra=1 rb=2 → next cycle imem_we=1, addr 0, wdata 0x00A; word_count=1.
- ADDI ra=5 imm=-3, then LOD ra=2 rb=5 back-to-back → words 0x11D at addr 0, 0x0E5 at addr 1, on consecutive cycles; req_ready stays 1.
- ADDIW ra=6 imm=14 → 0x127 at addr 0 and 0x127 at addr 1; req_ready=0 for one cycle. ADDIW ra=6 imm=-16 → 0x128 twice.
- Illegal inputs: SHIFT mode=001, LOD ra=5, ADDI imm=9, op=12 → no writes, err=1, word_count unchanged. clear → err=0, word_count=0.
- DEPTH=4: fill with STO ra=1 rb=3 (0x0DB) ×3, then ADDIW → dropped, err=1. Then BRANCH ra=3 mode=001 → 0x199 at addr 3; full=1, req_ready=0.
- Reset asserted during EMIT2 → all outputs 0 immediately, no second word after release; next request writes addr 0.
